// File: rtl/plot_scheduler.sv
// Arbitrates the VGA adapter's single pixel-write port between four player heads
// (one rotating slot each per game step) and a full-screen background sweep.
module plot_scheduler #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        tick,
    input  logic        clear_req,
    input  logic [3:0]  alive,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    localparam logic [8:0] X_LIM  = 9'(X_MAX);
    localparam logic [7:0] Y_LIM  = 8'(Y_MAX);
    localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             tick_pend_q, tick_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic [1:0]       start_q, start_d;
    logic [3:0][14:0] snap_q, snap_d;
    logic [3:0]       alive_snap_q, alive_snap_d;
    logic [2:0]       slot_q, slot_d;
    logic [7:0]       cx_q, cx_d;
    logic [6:0]       cy_q, cy_d;
    logic             sweep_end_q, sweep_end_d;

    logic [1:0]       player;
    logic [7:0]       sx;
    logic [6:0]       sy;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        busy_d       = (state_q != S_IDLE);
        overrun_d    = overrun_q;
        tick_pend_d  = tick_pend_q;
        clr_pend_d   = clr_pend_q;
        start_d      = start_q;
        snap_d       = snap_q;
        alive_snap_d = alive_snap_q;
        slot_d       = slot_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        sweep_end_d  = sweep_end_q;
        player       = start_q + slot_q[1:0];
        sx           = snap_q[player][14:7];
        sy           = snap_q[player][6:0];

        // A tick that cannot be served now is parked once; a second one is lost.
        if (tick && (state_q != S_IDLE || clear_req || clr_pend_q)) begin
            if (tick_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                tick_pend_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d     = S_CLEAR;
                    clr_pend_d  = 1'b0;
                    cx_d        = 8'd0;
                    cy_d        = 7'd0;
                    sweep_end_d = 1'b0;
                end else if (tick || tick_pend_q) begin
                    state_d      = S_DRAW;
                    snap_d       = {p4, p3, p2, p1};
                    alive_snap_d = alive;
                    tick_pend_d  = 1'b0;
                    slot_d       = 3'd0;
                end
            end
            S_CLEAR: begin
                if (sweep_end_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    x_d      = cx_q;
                    y_d      = cy_q;
                    colour_d = BG_COLOUR;
                    plot_d   = 1'b1;
                    if (cx_q == X_LAST) begin
                        cx_d = 8'd0;
                        if (cy_q == Y_LAST) begin
                            sweep_end_d = 1'b1;
                        end else begin
                            cy_d = cy_q + 7'd1;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            S_DRAW: begin
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (slot_q == 3'd4) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    start_d = start_q + 2'd1;
                end else begin
                    slot_d = slot_q + 3'd1;
                    // Dead or off-screen heads burn their slot without touching the port.
                    if (alive_snap_q[player] && ({1'b0, sx} < X_LIM) && ({1'b0, sy} < Y_LIM)) begin
                        x_d    = sx;
                        y_d    = sy;
                        plot_d = 1'b1;
                        case (player)
                            2'd0:    colour_d = 3'b001;
                            2'd1:    colour_d = 3'b010;
                            2'd2:    colour_d = 3'b100;
                            default: colour_d = 3'b110;
                        endcase
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            tick_pend_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
            start_q      <= 2'd0;
            snap_q       <= '0;
            alive_snap_q <= 4'd0;
            slot_q       <= 3'd0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            sweep_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            tick_pend_q  <= tick_pend_d;
            clr_pend_q   <= clr_pend_d;
            start_q      <= start_d;
            snap_q       <= snap_d;
            alive_snap_q <= alive_snap_d;
            slot_q       <= slot_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            sweep_end_q  <= sweep_end_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
